// File: rtl/ifetch_unit_pkg.sv
// Shared core definitions for instruction fetch: exception causes, NOP encoding,
// reset PC default and the fetch-packet layout consumed by decode.
package ifetch_unit_pkg;

  localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;
  localparam logic [31:0] NOP_ENC              = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEF         = 64'h0000_0000_0000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } fetch_pkt_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: redirect input, combinational imem port and the decode handshake.
interface ifetch_unit_if;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_pc_addr;
  logic [31:0] imem_instruction;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;

  modport master (
    input  redirect_en, redirect_pc, imem_instruction, imem_exc_en,
           imem_exc_code, imem_exc_val, out_ready,
    output imem_pc_addr, out_valid, out_pc, out_instr, out_exc_en,
           out_exc_code, out_exc_val
  );

  modport slave (
    output redirect_en, redirect_pc, imem_instruction, imem_exc_en,
           imem_exc_code, imem_exc_val, out_ready,
    input  imem_pc_addr, out_valid, out_pc, out_instr, out_exc_en,
           out_exc_code, out_exc_val
  );
endinterface

// File: rtl/ifetch_unit_fetch_slot.sv
// Single-entry output register for fetch packets; flush beats load beats pop,
// and the packet fields hold while the entry is not reloaded.
module fetch_slot
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic       pop,
  input  fetch_pkt_t pkt_in,
  output logic       valid,
  output fetch_pkt_t pkt_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      pkt_out <= '{pc: '0, instr: NOP_INSTR, exc_en: 1'b0, exc_code: '0, exc_val: '0};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      pkt_out <= pkt_in;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, probes the combinational imem and
// fills a one-entry output slot; stops fetching after a fault until redirected.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  logic [63:0]  pc, pc_nxt;
  fetch_state_t state, state_nxt;
  logic         slot_valid, slot_free, fire, load;
  fetch_pkt_t   new_pkt, slot_pkt;

  assign fire      = slot_valid && bus.out_ready;
  assign slot_free = !slot_valid || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  // Redirect wins over fetch and consumes the cycle; a fault parks the PC on the faulting address.
  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    load      = 1'b0;
    new_pkt   = '{pc: pc, instr: NOP_INSTR, exc_en: 1'b0,
                  exc_code: EXC_INSTR_MISALIGNED, exc_val: '0};
    if (bus.redirect_en) begin
      pc_nxt    = bus.redirect_pc;
      state_nxt = ST_RUN;
    end else if (state == ST_RUN && slot_free) begin
      load = 1'b1;
      if (pc[1:0] != 2'b00) begin
        new_pkt.exc_en  = 1'b1;
        new_pkt.exc_val = pc;
        state_nxt       = ST_HALT;
      end else if (bus.imem_exc_en) begin
        new_pkt.exc_en   = 1'b1;
        new_pkt.exc_code = bus.imem_exc_code;
        new_pkt.exc_val  = bus.imem_exc_val;
        state_nxt        = ST_HALT;
      end else begin
        new_pkt.instr = bus.imem_instruction;
        pc_nxt        = pc + 64'd4;
      end
    end
  end

  fetch_slot #(.NOP_INSTR(NOP_INSTR)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (bus.redirect_en),
    .pop     (fire),
    .pkt_in  (new_pkt),
    .valid   (slot_valid),
    .pkt_out (slot_pkt)
  );

  assign bus.imem_pc_addr = pc;
  assign bus.out_valid    = slot_valid;
  assign bus.out_pc       = slot_pkt.pc;
  assign bus.out_instr    = slot_pkt.instr;
  assign bus.out_exc_en   = slot_pkt.exc_en;
  assign bus.out_exc_code = slot_pkt.exc_code;
  assign bus.out_exc_val  = slot_pkt.exc_val;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a combinational imem model and hand-computed expectations.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic        exc_force;
  logic [3:0]  exc_code_drv;
  logic [63:0] exc_val_drv;

  ifetch_unit_if bus ();

  ifetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  always_comb begin
    case (bus.imem_pc_addr)
      64'h0:   bus.imem_instruction = 32'h0050_0093;
      64'h4:   bus.imem_instruction = 32'h00A0_0113;
      default: bus.imem_instruction = {4'h7, bus.imem_pc_addr[27:0]};
    endcase
    bus.imem_exc_en   = exc_force;
    bus.imem_exc_code = exc_code_drv;
    bus.imem_exc_val  = exc_val_drv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = tgt;
    tick();
    bus.redirect_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
    exc_force = 1'b0; exc_code_drv = '0; exc_val_drv = '0;
    rst = 1'b1;
    #3;
    n_vec++; if (bus.out_valid !== 1'b0) begin $display("FAIL rst_valid got %b exp 0", bus.out_valid); n_err++; end
    n_vec++; if (bus.out_pc !== 64'h0) begin $display("FAIL rst_pc got %h exp 0", bus.out_pc); n_err++; end
    n_vec++; if (bus.out_instr !== 32'h13) begin $display("FAIL rst_instr got %h exp 00000013", bus.out_instr); n_err++; end
    n_vec++; if ({bus.out_exc_en, bus.out_exc_code, bus.out_exc_val} !== 69'h0) begin $display("FAIL rst_exc got %b/%h/%h exp 0", bus.out_exc_en, bus.out_exc_code, bus.out_exc_val); n_err++; end
    n_vec++; if (bus.imem_pc_addr !== 64'h0) begin $display("FAIL rst_addr got %h exp 0", bus.imem_pc_addr); n_err++; end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin $display("FAIL stream0_pc got %b/%h exp 1/0", bus.out_valid, bus.out_pc); n_err++; end
    n_vec++; if (bus.out_instr !== 32'h0050_0093 || bus.out_exc_en !== 1'b0) begin $display("FAIL stream0_instr got %h/%b exp 00500093/0", bus.out_instr, bus.out_exc_en); n_err++; end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h4) begin $display("FAIL stream1_pc got %b/%h exp 1/4", bus.out_valid, bus.out_pc); n_err++; end
    n_vec++; if (bus.out_instr !== 32'h00A0_0113 || bus.out_exc_en !== 1'b0) begin $display("FAIL stream1_instr got %h/%b exp 00a00113/0", bus.out_instr, bus.out_exc_en); n_err++; end
    n_vec++; if (bus.imem_pc_addr !== 64'h8) begin $display("FAIL stream_addr got %h exp 8", bus.imem_pc_addr); n_err++; end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    do_reset();
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin $display("FAIL stall_first got %b/%h exp 1/0", bus.out_valid, bus.out_pc); n_err++; end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0050_0093) begin $display("FAIL stall_hold%0d got %b/%h/%h exp 1/0/00500093", i, bus.out_valid, bus.out_pc, bus.out_instr); n_err++; end
      n_vec++; if (bus.imem_pc_addr !== 64'h4) begin $display("FAIL stall_addr%0d got %h exp 4", i, bus.imem_pc_addr); n_err++; end
    end
    bus.out_ready = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h4 || bus.out_instr !== 32'h00A0_0113) begin $display("FAIL stall_resume got %b/%h/%h exp 1/4/00a00113", bus.out_valid, bus.out_pc, bus.out_instr); n_err++; end
    tick();
    n_vec++; if (bus.out_pc !== 64'h8 || bus.out_instr !== 32'h7000_0008) begin $display("FAIL stall_next got %h/%h exp 8/70000008", bus.out_pc, bus.out_instr); n_err++; end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h8) begin $display("FAIL arst_pre got %b/%h exp 1/8", bus.out_valid, bus.out_pc); n_err++; end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin $display("FAIL arst_valid got %b exp 0", bus.out_valid); n_err++; end
    n_vec++; if (bus.imem_pc_addr !== 64'h0) begin $display("FAIL arst_addr got %h exp 0", bus.imem_pc_addr); n_err++; end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fault_halt();
    exc_force = 1'b1; exc_code_drv = 4'd1; exc_val_drv = 64'h2000;
    redirect(64'h2000);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.imem_pc_addr !== 64'h2000) begin $display("FAIL fault_redir got %b/%h exp 0/2000", bus.out_valid, bus.imem_pc_addr); n_err++; end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h2000 || bus.out_instr !== 32'h13) begin $display("FAIL fault_pkt got %b/%h/%h exp 1/2000/00000013", bus.out_valid, bus.out_pc, bus.out_instr); n_err++; end
    n_vec++; if (bus.out_exc_en !== 1'b1 || bus.out_exc_code !== 4'd1 || bus.out_exc_val !== 64'h2000) begin $display("FAIL fault_exc got %b/%h/%h exp 1/1/2000", bus.out_exc_en, bus.out_exc_code, bus.out_exc_val); n_err++; end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exc_force = i[0];
      n_vec++; if (bus.out_valid !== 1'b0 || bus.imem_pc_addr !== 64'h2000) begin $display("FAIL halt_idle%0d got %b/%h exp 0/2000", i, bus.out_valid, bus.imem_pc_addr); n_err++; end
    end
    exc_force = 1'b0;
    bus.redirect_en = 1'b1; bus.redirect_pc = 64'h100;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin $display("FAIL halt_redir_cycle got %b exp 0", bus.out_valid); n_err++; end
    tick();
    bus.redirect_en = 1'b0;
    n_vec++; if (bus.imem_pc_addr !== 64'h100 || bus.out_valid !== 1'b0) begin $display("FAIL halt_redir_addr got %h/%b exp 100/0", bus.imem_pc_addr, bus.out_valid); n_err++; end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100 || bus.out_instr !== 32'h7000_0100 || bus.out_exc_en !== 1'b0) begin $display("FAIL halt_resume got %b/%h/%h/%b exp 1/100/70000100/0", bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc_en); n_err++; end
  endtask

  task automatic test_misaligned();
    exc_force = 1'b1; exc_code_drv = 4'd5; exc_val_drv = 64'hDEAD;
    redirect(64'h102);
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h102 || bus.out_instr !== 32'h13) begin $display("FAIL mis_pkt got %b/%h/%h exp 1/102/00000013", bus.out_valid, bus.out_pc, bus.out_instr); n_err++; end
    n_vec++; if (bus.out_exc_en !== 1'b1 || bus.out_exc_code !== 4'd0 || bus.out_exc_val !== 64'h102) begin $display("FAIL mis_exc got %b/%h/%h exp 1/0/102", bus.out_exc_en, bus.out_exc_code, bus.out_exc_val); n_err++; end
    exc_force = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.out_valid !== 1'b0 || bus.imem_pc_addr !== 64'h102) begin $display("FAIL mis_halt got %b/%h exp 0/102", bus.out_valid, bus.imem_pc_addr); n_err++; end
  endtask

  task automatic test_back_to_back();
    redirect(64'h200);
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200) begin $display("FAIL b2b_pre got %b/%h exp 1/200", bus.out_valid, bus.out_pc); n_err++; end
    redirect(64'h300);
    n_vec++; if (bus.out_valid !== 1'b0 || bus.imem_pc_addr !== 64'h300) begin $display("FAIL b2b_flush got %b/%h exp 0/300", bus.out_valid, bus.imem_pc_addr); n_err++; end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h300) begin $display("FAIL b2b_target got %b/%h exp 1/300", bus.out_valid, bus.out_pc); n_err++; end
  endtask

  task automatic test_wrap();
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    n_vec++; if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.out_exc_en !== 1'b0) begin $display("FAIL wrap_pkt got %h/%b exp fffffffffffffffc/0", bus.out_pc, bus.out_exc_en); n_err++; end
    n_vec++; if (bus.imem_pc_addr !== 64'h0) begin $display("FAIL wrap_addr got %h exp 0", bus.imem_pc_addr); n_err++; end
    tick();
    n_vec++; if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0050_0093) begin $display("FAIL wrap_next got %h/%h exp 0/00500093", bus.out_pc, bus.out_instr); n_err++; end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_async_reset();
    test_fault_halt();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
